// File: rtl/dmem_mmio_router_pkg.sv
// Shared definitions for the data-memory / MMIO router.
// Provides the MMIO word offsets (addr[4:2]), the core's funct3 size codes
// and the UART transmitter state type.
package dmem_mmio_router_pkg;

  // MMIO word index within the window (addr[4:2])
  localparam logic [2:0] OffMtimeLo    = 3'd0;
  localparam logic [2:0] OffMtimeHi    = 3'd1;
  localparam logic [2:0] OffMtimecmpLo = 3'd2;
  localparam logic [2:0] OffMtimecmpHi = 3'd3;
  localparam logic [2:0] OffUartTxdata = 3'd4;
  localparam logic [2:0] OffUartStatus = 3'd5;

  // dmemSize (funct3) encodings
  localparam logic [2:0] SizeB  = 3'd0;
  localparam logic [2:0] SizeH  = 3'd1;
  localparam logic [2:0] SizeW  = 3'd2;
  localparam logic [2:0] SizeBu = 3'd4;
  localparam logic [2:0] SizeHu = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_t;

endpackage

// File: rtl/dmem_mmio_router_uart_tx.sv
// 8N1 UART transmitter fronted by a small TX FIFO.
//   clk_i, rst_ni  clock / async active-low reset
//   push_i, data_i enqueue a byte (dropped when full, which sets overflow)
//   ovf_clr_i      clears the sticky overflow flag
//   full_o         FIFO holds FifoDepth entries
//   busy_o         frame in progress or bytes still queued
//   overflow_o     sticky: a push was dropped
//   tx_o           serial line, idles high
module dmem_mmio_router_uart_tx
  import dmem_mmio_router_pkg::*;
#(
  parameter int unsigned BaudDiv   = 868,
  parameter int unsigned FifoDepth = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       ovf_clr_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic       tx_o
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned BaudW = $clog2(BaudDiv);
  localparam logic [PtrW:0]    FullCnt  = (PtrW + 1)'(FifoDepth);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BaudDiv - 1);

  logic [7:0]       mem_q [FifoDepth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q, count_d;
  uart_state_t      state_q, state_d;
  logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             overflow_q, overflow_d;
  logic             push_ok, pop, full, fifo_empty, baud_wrap;

  assign full       = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  // A full FIFO rejects the push even when a pop frees a slot this cycle.
  assign push_ok    = push_i & ~full;
  assign baud_wrap  = (baud_cnt_q == BaudLast);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    pop        = 1'b0;
    if (state_q != StIdle) begin
      baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          data_d     = mem_q[rd_ptr_q];
          baud_cnt_d = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (baud_wrap) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (baud_wrap) begin
          // Chain straight into the next start bit: no idle gap between frames.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d    = count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop);
    overflow_d = ovf_clr_i ? 1'b0 : overflow_q;
    if (push_i && full) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      StStart: tx_o = 1'b0;
      StData:  tx_o = data_q[bit_idx_q];
      default: tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_q + PtrW'(push_ok);
      rd_ptr_q   <= rd_ptr_q + PtrW'(pop);
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign full_o     = full;
  assign busy_o     = (state_q != StIdle) | ~fifo_empty;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/dmem_mmio_router.sv
// Router between the core's data-memory port, the synchronous data RAM and a
// 4 KB MMIO window holding a 64-bit machine timer and a UART transmitter.
//   clk, rst                    clock / async active-low reset
//   dmem*                       core access (addr, wdata, size, wen, ren, rdata)
//   ram*                        RAM passthrough; strobes gated off on MMIO hits
//   uartTx                      serial output, idles high
//   timerIrq                    registered mtime >= mtimecmp
// Loads return one cycle after dmemRen for both regions; no stalls.
module dmem_mmio_router
  import dmem_mmio_router_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
  parameter int unsigned TICK_DIV      = 1,
  parameter int unsigned BAUD_DIV      = 868,
  parameter int unsigned TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemAddr,
  input  logic [31:0] dmemWdata,
  input  logic [2:0]  dmemSize,
  input  logic        dmemWen,
  input  logic        dmemRen,
  output logic [31:0] dmemRdata,
  output logic [31:0] ramAddr,
  output logic [31:0] ramWdata,
  output logic [2:0]  ramSize,
  output logic        ramWen,
  output logic        ramRen,
  input  logic [31:0] ramRdata,
  output logic        uartTx,
  output logic        timerIrq
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  logic             mmio_hit, in_map, mmio_wr, tick;
  logic [2:0]       word;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [63:0]      mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic             timer_irq_q, timer_irq_d;
  logic             rd_valid_q, rd_sel_mmio_q;
  logic [31:0]      mmio_rdata, mmio_rd_q, rdata_hold_q, rd_mux;
  logic             uart_full, uart_busy, uart_overflow;
  logic             unused_addr;

  assign mmio_hit = (dmemAddr[31:12] == MMIO_BASE[31:12]);
  // Offsets past the last register word read 0 and ignore writes.
  assign in_map   = (dmemAddr[11:5] == 7'd0);
  assign word     = dmemAddr[4:2];
  assign mmio_wr  = dmemWen & mmio_hit & in_map;
  assign unused_addr = ^dmemAddr[1:0];

  assign ramAddr  = dmemAddr;
  assign ramWdata = dmemWdata;
  assign ramSize  = dmemSize;
  assign ramWen   = dmemWen & ~mmio_hit;
  assign ramRen   = dmemRen & ~mmio_hit;

  // Timer: a write to either half pre-empts that cycle's tick entirely.
  assign tick = (tick_cnt_q == TickLast);
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (mmio_wr && word == OffMtimeLo) begin
      mtime_d[31:0] = dmemWdata;
    end else if (mmio_wr && word == OffMtimeHi) begin
      mtime_d[63:32] = dmemWdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (mmio_wr && word == OffMtimecmpLo) begin
      mtimecmp_d[31:0] = dmemWdata;
    end
    if (mmio_wr && word == OffMtimecmpHi) begin
      mtimecmp_d[63:32] = dmemWdata;
    end
    timer_irq_d = (mtime_q >= mtimecmp_q);
  end

  // Read mux sees pre-write register values, so a same-cycle store is not visible.
  always_comb begin
    mmio_rdata = '0;
    if (in_map) begin
      case (word)
        OffMtimeLo:    mmio_rdata = mtime_q[31:0];
        OffMtimeHi:    mmio_rdata = mtime_q[63:32];
        OffMtimecmpLo: mmio_rdata = mtimecmp_q[31:0];
        OffMtimecmpHi: mmio_rdata = mtimecmp_q[63:32];
        OffUartStatus: mmio_rdata = {29'd0, uart_overflow, uart_busy, uart_full};
        default:       mmio_rdata = '0;
      endcase
    end
  end

  assign rd_mux    = rd_sel_mmio_q ? mmio_rd_q : ramRdata;
  assign dmemRdata = rd_valid_q ? rd_mux : rdata_hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q    <= '0;
      mtime_q       <= '0;
      mtimecmp_q    <= '1;
      timer_irq_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_sel_mmio_q <= 1'b0;
      mmio_rd_q     <= '0;
      rdata_hold_q  <= '0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      mtime_q       <= mtime_d;
      mtimecmp_q    <= mtimecmp_d;
      timer_irq_q   <= timer_irq_d;
      rd_valid_q    <= dmemRen;
      rd_sel_mmio_q <= dmemRen & mmio_hit;
      if (dmemRen) begin
        mmio_rd_q <= mmio_rdata;
      end
      if (rd_valid_q) begin
        rdata_hold_q <= rd_mux;
      end
    end
  end

  assign timerIrq = timer_irq_q;

  dmem_mmio_router_uart_tx #(
    .BaudDiv  (BAUD_DIV),
    .FifoDepth(TX_FIFO_DEPTH)
  ) u_uart_tx (
    .clk_i     (clk),
    .rst_ni    (rst),
    .push_i    (mmio_wr & (word == OffUartTxdata)),
    .data_i    (dmemWdata[7:0]),
    .ovf_clr_i (mmio_wr & (word == OffUartStatus) & dmemWdata[2]),
    .full_o    (uart_full),
    .busy_o    (uart_busy),
    .overflow_o(uart_overflow),
    .tx_o      (uartTx)
  );

endmodule
